// File: rtl/inert_intf.sv
// inert_intf: producer side of the vld / ptch_rt / AZ interface feeding inertial_integrator.
//
// After a power-on delay the block writes four configuration registers into the IMU through
// the SPI transactor. It then waits for the (synchronized) data-ready interrupt and reads
// PL, PH, AL and AH back to back. Once AH arrives it presents the assembled 16-bit samples
// with a one-cycle vld pulse.
//
// Ports:
//   clk      in   system clock
//   rst_n    in   asynchronous active-low reset
//   INT      in   IMU data-ready interrupt (asynchronous, double-flopped here)
//   done     in   SPI transaction complete pulse; rd_data valid in the same cycle
//   rd_data  in   SPI response word, only [7:0] is used
//   wrt      out  one-cycle pulse starting an SPI transaction with cmd
//   cmd      out  SPI command word, held from wrt until the matching done
//   vld      out  one-cycle pulse: ptch_rt / AZ hold a fresh sample
//   ptch_rt  out  signed pitch rate {PH, PL}
//   AZ       out  signed Z acceleration {AH, AL}

module inert_intf #(
    parameter int unsigned INIT_WAIT_BITS = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        INT,
    input  logic        done,
    input  logic [15:0] rd_data,
    output logic        wrt,
    output logic [15:0] cmd,
    output logic        vld,
    output logic [15:0] ptch_rt,
    output logic [15:0] AZ
);

    typedef enum logic [3:0] {
        StPwrWait,
        StInit1,
        StInit2,
        StInit3,
        StInit4,
        StWaitInt,
        StRdPl,
        StRdPh,
        StRdAl,
        StRdAh
    } state_e;

    localparam logic [INIT_WAIT_BITS-1:0] TimerMax = '1;
    localparam logic [INIT_WAIT_BITS-1:0] TimerOne = INIT_WAIT_BITS'(1);

    // Configuration writes
    localparam logic [15:0] CmdIntCfg = 16'h0D02;
    localparam logic [15:0] CmdAccCfg = 16'h1053;
    localparam logic [15:0] CmdGyrCfg = 16'h1150;
    localparam logic [15:0] CmdRndCfg = 16'h1460;
    // Reads (bit 15 set marks a read)
    localparam logic [15:0] CmdRdPl   = 16'hA200;
    localparam logic [15:0] CmdRdPh   = 16'hA300;
    localparam logic [15:0] CmdRdAl   = 16'hAC00;
    localparam logic [15:0] CmdRdAh   = 16'hAD00;

    state_e                    state_q, state_d;
    logic [INIT_WAIT_BITS-1:0] timer_q, timer_d;
    logic                      int_meta_q, int_s_q;
    logic                      wrt_q, wrt_d;
    logic [15:0]               cmd_q, cmd_d;
    logic                      vld_q, vld_d;
    logic [15:0]               ptch_q, ptch_d;
    logic [15:0]               az_q, az_d;
    logic [7:0]                pl_q, pl_d;
    logic [7:0]                ph_q, ph_d;
    logic [7:0]                al_q, al_d;

    // Upper response byte carries nothing for this block.
    logic unused_rd_hi;
    assign unused_rd_hi = ^rd_data[15:8];

    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        wrt_d   = 1'b0;
        cmd_d   = cmd_q;
        vld_d   = 1'b0;
        ptch_d  = ptch_q;
        az_d    = az_q;
        pl_d    = pl_q;
        ph_d    = ph_q;
        al_d    = al_q;

        unique case (state_q)
            StPwrWait: begin
                if (timer_q != TimerMax) begin
                    timer_d = timer_q + TimerOne;
                end
                // Launch init on the edge where the counter reaches all-ones.
                if (timer_d == TimerMax) begin
                    state_d = StInit1;
                    wrt_d   = 1'b1;
                    cmd_d   = CmdIntCfg;
                end
            end
            StInit1: begin
                if (done) begin
                    state_d = StInit2;
                    wrt_d   = 1'b1;
                    cmd_d   = CmdAccCfg;
                end
            end
            StInit2: begin
                if (done) begin
                    state_d = StInit3;
                    wrt_d   = 1'b1;
                    cmd_d   = CmdGyrCfg;
                end
            end
            StInit3: begin
                if (done) begin
                    state_d = StInit4;
                    wrt_d   = 1'b1;
                    cmd_d   = CmdRndCfg;
                end
            end
            StInit4: begin
                if (done) begin
                    state_d = StWaitInt;
                end
            end
            StWaitInt: begin
                // Level-sensitive: a held INT chains sequences back to back.
                if (int_s_q) begin
                    state_d = StRdPl;
                    wrt_d   = 1'b1;
                    cmd_d   = CmdRdPl;
                end
            end
            StRdPl: begin
                if (done) begin
                    pl_d    = rd_data[7:0];
                    state_d = StRdPh;
                    wrt_d   = 1'b1;
                    cmd_d   = CmdRdPh;
                end
            end
            StRdPh: begin
                if (done) begin
                    ph_d    = rd_data[7:0];
                    state_d = StRdAl;
                    wrt_d   = 1'b1;
                    cmd_d   = CmdRdAl;
                end
            end
            StRdAl: begin
                if (done) begin
                    al_d    = rd_data[7:0];
                    state_d = StRdAh;
                    wrt_d   = 1'b1;
                    cmd_d   = CmdRdAh;
                end
            end
            StRdAh: begin
                if (done) begin
                    // AH goes straight from the response into the output register.
                    ptch_d  = {ph_q, pl_q};
                    az_d    = {rd_data[7:0], al_q};
                    vld_d   = 1'b1;
                    state_d = StWaitInt;
                end
            end
            default: begin
                state_d = StPwrWait;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StPwrWait;
            timer_q    <= '0;
            int_meta_q <= 1'b0;
            int_s_q    <= 1'b0;
            wrt_q      <= 1'b0;
            cmd_q      <= 16'h0000;
            vld_q      <= 1'b0;
            ptch_q     <= 16'h0000;
            az_q       <= 16'h0000;
            pl_q       <= 8'h00;
            ph_q       <= 8'h00;
            al_q       <= 8'h00;
        end else begin
            state_q    <= state_d;
            timer_q    <= timer_d;
            int_meta_q <= INT;
            int_s_q    <= int_meta_q;
            wrt_q      <= wrt_d;
            cmd_q      <= cmd_d;
            vld_q      <= vld_d;
            ptch_q     <= ptch_d;
            az_q       <= az_d;
            pl_q       <= pl_d;
            ph_q       <= ph_d;
            al_q       <= al_d;
        end
    end

    assign wrt     = wrt_q;
    assign cmd     = cmd_q;
    assign vld     = vld_q;
    assign ptch_rt = ptch_q;
    assign AZ      = az_q;

endmodule

// File: tb/tb_inert_intf.sv
// Testbench for inert_intf: SPI slave model with a register map, protocol monitor and
// directed plus randomized sample sequences.

module tb_inert_intf;

    localparam int SpiLat = 8;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        INT;
    logic        spi_done;
    logic        spur_done;
    logic        done;
    logic [15:0] rd_data;
    logic        wrt;
    logic [15:0] cmd;
    logic        vld;
    logic [15:0] ptch_rt;
    logic [15:0] AZ;

    assign done = spi_done | spur_done;

    always #5 clk = ~clk;

    inert_intf #(
        .INIT_WAIT_BITS(4)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .INT    (INT),
        .done   (done),
        .rd_data(rd_data),
        .wrt    (wrt),
        .cmd    (cmd),
        .vld    (vld),
        .ptch_rt(ptch_rt),
        .AZ     (AZ)
    );

    int n_checks = 0;
    int n_errors = 0;

    int cyc      = 0;
    int rel_cyc  = 0;
    int done_cyc = 0;
    int vld_cyc  = 0;
    int wrt_cnt  = 0;
    int vld_cnt  = 0;
    int ptr      = 0;
    bit held_chk = 1'b0;

    logic [15:0] prev_p = 16'h0000;
    logic [15:0] prev_a = 16'h0000;
    logic [7:0]  regmap [0:127];
    logic [7:0]  served [0:127];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Transaction order seen on the bus: four init writes once, then PL/PH/AL/AH reads.
    function automatic logic [15:0] exp_cmd(input int p);
        case (p)
            0:       return 16'h0D02;
            1:       return 16'h1053;
            2:       return 16'h1150;
            3:       return 16'h1460;
            4:       return 16'hA200;
            5:       return 16'hA300;
            6:       return 16'hAC00;
            default: return 16'hAD00;
        endcase
    endfunction

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    // SPI slave: done SpiLat cycles after wrt, response from the register map.
    task automatic serve();
        logic [15:0] held;
        bit          aborted;
        int          n;
        held    = cmd;
        aborted = 1'b0;
        n       = 0;
        while (n < SpiLat && !aborted) begin
            @(posedge clk);
            #1;
            if (!rst_n) begin
                aborted = 1'b1;
            end else begin
                if (n == 0) check_eq("wrt_one_cycle", 32'(wrt), 32'd0);
                check_eq("cmd_hold", 32'(cmd), 32'(held));
                n++;
            end
        end
        if (!aborted) begin
            served[held[14:8]] = regmap[held[14:8]];
            rd_data  = {8'($urandom), regmap[held[14:8]]};
            spi_done = 1'b1;
            @(posedge clk);
            #1;
            spi_done = 1'b0;
            rd_data  = 16'($urandom);
        end
    endtask

    initial begin
        spi_done = 1'b0;
        rd_data  = 16'h0000;
        forever begin
            @(posedge clk);
            #1;
            while (rst_n && wrt) serve();
        end
    end

    // Protocol monitor, sampled on the falling edge.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                ptr    = 0;
                prev_p = 16'h0000;
                prev_a = 16'h0000;
            end else begin
                if (wrt) begin
                    wrt_cnt++;
                    check_eq("cmd_order", 32'(cmd), 32'(exp_cmd(ptr)));
                    if (ptr == 0) begin
                        check_eq("pwr_on_latency", 32'(cyc - rel_cyc), 32'd15);
                    end else if (exp_cmd(ptr) != 16'hA200) begin
                        check_eq("wrt_after_done", 32'(cyc - done_cyc), 32'd1);
                    end else if (held_chk) begin
                        check_eq("reissue_after_vld", 32'(cyc - vld_cyc), 32'd1);
                    end
                    ptr = (ptr == 7) ? 4 : ptr + 1;
                end
                if (done) done_cyc = cyc;
                if (vld) begin
                    vld_cnt++;
                    vld_cyc = cyc;
                    check_eq("vld_ptch", 32'(ptch_rt), 32'({served[7'h23], served[7'h22]}));
                    check_eq("vld_az", 32'(AZ), 32'({served[7'h2D], served[7'h2C]}));
                end else begin
                    check_eq("ptch_stable", 32'(ptch_rt), 32'(prev_p));
                    check_eq("az_stable", 32'(AZ), 32'(prev_a));
                end
                prev_p = ptch_rt;
                prev_a = AZ;
            end
        end
    end

    task automatic wait_vld(input int target, input int budget);
        for (int i = 0; i < budget && vld_cnt < target; i++) begin
            @(negedge clk);
            #1;
        end
        check_eq("vld_count", 32'(vld_cnt), 32'(target));
    endtask

    task automatic wait_wrt(input int target, input int budget);
        for (int i = 0; i < budget && wrt_cnt < target; i++) begin
            @(negedge clk);
            #1;
        end
        check_eq("wrt_count", 32'(wrt_cnt), 32'(target));
    endtask

    task automatic wait_cmd(input logic [15:0] c, input int budget);
        bit found;
        found = 1'b0;
        for (int i = 0; i < budget && !found; i++) begin
            @(negedge clk);
            #1;
            if (wrt && cmd == c) found = 1'b1;
        end
        check_eq("cmd_seen", 32'(found), 32'd1);
    endtask

    task automatic pulse_int(input int w);
        @(posedge clk);
        #2 INT = 1'b1;
        repeat (w) @(posedge clk);
        #2 INT = 1'b0;
    endtask

    task automatic set_bytes(input logic [7:0] pl, input logic [7:0] ph,
                             input logic [7:0] al, input logic [7:0] ah);
        regmap[7'h22] = pl;
        regmap[7'h23] = ph;
        regmap[7'h2C] = al;
        regmap[7'h2D] = ah;
    endtask

    task automatic do_sample(input logic [7:0] pl, input logic [7:0] ph,
                             input logic [7:0] al, input logic [7:0] ah, input int w);
        int target;
        set_bytes(pl, ph, al, ah);
        target = vld_cnt + 1;
        pulse_int(w);
        wait_vld(target, 200);
        check_eq("ptch_rt", 32'(ptch_rt), 32'({ph, pl}));
        check_eq("AZ", 32'(AZ), 32'({ah, al}));
        repeat (10) @(negedge clk);
        check_eq("single_vld", 32'(vld_cnt), 32'(target));
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_wrt"}, 32'(wrt), 32'd0);
        check_eq({tag, "_vld"}, 32'(vld), 32'd0);
        check_eq({tag, "_cmd"}, 32'(cmd), 32'd0);
        check_eq({tag, "_ptch"}, 32'(ptch_rt), 32'd0);
        check_eq({tag, "_az"}, 32'(AZ), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int w0;
        int v0;
        rst_n     = 1'b0;
        INT       = 1'b0;
        spur_done = 1'b0;
        for (int i = 0; i < 128; i++) begin
            regmap[i] = 8'($urandom);
            served[i] = 8'h00;
        end

        // Reset state
        repeat (3) @(negedge clk);
        check_all_zero("reset");

        // Power-on init: 15 cycles to the first wrt, then four writes chained off done
        @(posedge clk);
        #2 rst_n = 1'b1;
        rel_cyc = cyc;
        wait_wrt(4, 200);
        repeat (12) @(negedge clk);
        check_eq("init_wrt_total", 32'(wrt_cnt), 32'd4);
        check_eq("init_no_vld", 32'(vld_cnt), 32'd0);

        // Directed samples
        do_sample(8'h50, 8'h10, 8'h00, 8'h08, 2);
        check_eq("sample_pos_ptch", 32'(ptch_rt), 32'h1050);
        do_sample(8'hB0, 8'hF0, 8'h00, 8'hF8, 2);
        check_eq("sample_neg_az", 32'(AZ), 32'hF800);

        // Randomized samples and INT pulse widths
        for (int k = 0; k < 6; k++) begin
            do_sample(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom),
                      int'($urandom_range(1, 3)));
        end

        // INT held high across three sequences
        set_bytes(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
        base = vld_cnt;
        @(posedge clk);
        #2 INT = 1'b1;
        wait_vld(base + 1, 200);
        held_chk = 1'b1;
        wait_vld(base + 2, 200);
        wait_cmd(16'hAD00, 200);
        @(posedge clk);
        #2 INT = 1'b0;
        wait_vld(base + 3, 200);
        repeat (30) @(negedge clk);
        held_chk = 1'b0;
        check_eq("held_vld_total", 32'(vld_cnt), 32'(base + 3));
        check_eq("held_ptch", 32'(ptch_rt), 32'({regmap[7'h23], regmap[7'h22]}));

        // Spurious done while idle
        w0 = wrt_cnt;
        v0 = vld_cnt;
        @(posedge clk);
        #2 spur_done = 1'b1;
        @(posedge clk);
        #2 spur_done = 1'b0;
        repeat (20) @(negedge clk);
        check_eq("spur_no_wrt", 32'(wrt_cnt), 32'(w0));
        check_eq("spur_no_vld", 32'(vld_cnt), 32'(v0));
        do_sample(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), 2);

        // Reset after PH read, before AL completes
        set_bytes(8'h11, 8'h22, 8'h33, 8'h44);
        v0 = vld_cnt;
        pulse_int(2);
        wait_cmd(16'hAC00, 200);
        #3 rst_n = 1'b0;
        #1;
        check_all_zero("async_reset");
        repeat (3) @(posedge clk);
        @(posedge clk);
        #2 rst_n = 1'b1;
        rel_cyc = cyc;
        w0      = wrt_cnt;
        wait_wrt(w0 + 4, 200);
        repeat (12) @(negedge clk);
        check_eq("abort_no_vld", 32'(vld_cnt), 32'(v0));
        check_eq("reinit_wrt_total", 32'(wrt_cnt), 32'(w0 + 4));
        do_sample(8'h5A, 8'hA5, 8'h3C, 8'hC3, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
